// File: rtl/jk_excitation_sequencer.sv
// Drives a bank of JK flip-flops toward a stream of target words: derives J/K
// excitation from (current, target), applies it, then self-checks the landing.

module jk_bit_cell #(
    parameter logic DC_ONE = 1'b0
) (
    input  logic q_i,
    input  logic t_i,
    input  logic j_i,
    input  logic k_i,
    output logic j_exc_o,
    output logic k_exc_o,
    output logic q_next_o
);
    // Inverse JK table: the "other" term of each transition is a don't-care.
    assign j_exc_o  = q_i ? DC_ONE : t_i;
    assign k_exc_o  = q_i ? ~t_i   : DC_ONE;
    assign q_next_o = (j_i & ~q_i) | (~k_i & q_i);
endmodule

module jk_excitation_sequencer #(
    parameter int   WIDTH  = 4,
    parameter logic DC_ONE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic             done,
    output logic             mismatch,
    output logic [7:0]       toggle_cnt
);
    typedef enum logic [1:0] {IDLE, EXCITE, APPLY, CHECK} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] q_prev_q, q_prev_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic             done_q, done_d;
    logic             mismatch_q, mismatch_d;
    logic [7:0]       cnt_q, cnt_d;

    logic [WIDTH-1:0] j_exc, k_exc, q_jk;
    logic [4:0]       flips;
    logic [8:0]       cnt_sum;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        jk_bit_cell #(.DC_ONE(DC_ONE)) u_cell (
            .q_i      (q_q[gi]),
            .t_i      (tgt_q[gi]),
            .j_i      (j_q[gi]),
            .k_i      (k_q[gi]),
            .j_exc_o  (j_exc[gi]),
            .k_exc_o  (k_exc[gi]),
            .q_next_o (q_jk[gi])
        );
    end

    always_comb begin
        flips = '0;
        for (int i = 0; i < WIDTH; i++) begin
            flips = flips + 5'(q_q[i] ^ q_prev_q[i]);
        end
        cnt_sum = {1'b0, cnt_q} + {4'b0, flips};
    end

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        q_d        = q_q;
        q_prev_d   = q_prev_q;
        j_d        = j_q;
        k_d        = k_q;
        done_d     = 1'b0;
        mismatch_d = mismatch_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (tgt_valid) begin
                    tgt_d   = tgt_data;
                    state_d = EXCITE;
                end
            end
            EXCITE: begin
                j_d     = j_exc;
                k_d     = k_exc;
                state_d = APPLY;
            end
            APPLY: begin
                q_prev_d = q_q;
                q_d      = q_jk;
                done_d   = 1'b1;
                state_d  = CHECK;
            end
            CHECK: begin
                if (q_q != tgt_q) mismatch_d = 1'b1;
                cnt_d   = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
                j_d     = '0;
                k_d     = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tgt_q      <= '0;
            q_q        <= '0;
            q_prev_q   <= '0;
            j_q        <= '0;
            k_q        <= '0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            q_q        <= q_d;
            q_prev_q   <= q_prev_d;
            j_q        <= j_d;
            k_q        <= k_d;
            done_q     <= done_d;
            mismatch_q <= mismatch_d;
            cnt_q      <= cnt_d;
        end
    end

    assign tgt_ready  = (state_q == IDLE) && !rst;
    assign j          = j_q;
    assign k          = k_q;
    assign q          = q_q;
    assign done       = done_q;
    assign mismatch   = mismatch_q;
    assign toggle_cnt = cnt_q;
endmodule
